ysyx_24110006_mem_arbiter: RTL and testbench
============================================

# ysyx_24110006_mem_arbiter

Two-requester memory arbiter that shares the core's single memory bus port between the instruction fetch unit (IFU) and the load/store path that follows the EXU (LSU). It accepts one transaction at a time, drives it onto the bus, waits for the response, and returns the response only to the requester that issued it. It sits between the IFU/LSU and the bus bridge.

## Interface
- No parameters; address and data are 32 bits, byte mask is 4 bits.
- i_clock  in  1  core clock
- i_reset  in  1  synchronous, active-low reset (0 = reset)
- i_ifu_valid  in  1  IFU read request
- o_ifu_ready  out  1  IFU request accepted this cycle
- i_ifu_addr  in  32  IFU fetch address
- i_ifu_flush  in  1  discard any outstanding IFU response
- o_ifu_rvalid  out  1  one-cycle IFU response pulse
- o_ifu_rdata  out  32  IFU read data
- o_ifu_rerr  out  1  IFU bus error
- i_lsu_valid  in  1  LSU request
- o_lsu_ready  out  1  LSU request accepted this cycle
- i_lsu_addr  in  32  LSU address
- i_lsu_wen  in  1  1 = write, 0 = read
- i_lsu_wdata  in  32  LSU write data
- i_lsu_wmask  in  4  LSU byte strobes
- o_lsu_rvalid  out  1  one-cycle LSU response pulse (reads and writes)
- o_lsu_rdata  out  32  LSU read data
- o_lsu_rerr  out  1  LSU bus error
- o_mem_valid  out  1  bus request valid
- i_mem_ready  in  1  bus accepts request
- o_mem_addr  out  32  bus address
- o_mem_wen  out  1  bus write
- o_mem_wdata  out  32  bus write data
- o_mem_wmask  out  4  bus byte strobes (0 on reads)
- i_mem_rvalid  in  1  bus response valid
- i_mem_rdata  in  32  bus read data
- i_mem_rerr  in  1  bus error with response

## Operation
- FSM states: IDLE, REQ, WAIT, RESP. Owner register: IFU or LSU.
- IDLE: if any valid is asserted, pick a winner. o_<winner>_ready = 1 combinationally, and the loser's ready = 0. Latch addr, wen, wdata, and wmask (IFU: wen = 0, wmask = 0), set owner, and go to REQ. Ready is never asserted outside IDLE.
- REQ: o_mem_valid = 1 with the latched fields held stable. When i_mem_ready = 1, go to WAIT.
- WAIT: on i_mem_rvalid, latch rdata and rerr and go to RESP. Ignore i_mem_rvalid in every other state.
- RESP: pulse o_<owner>_rvalid for exactly one cycle with the latched rdata/rerr, then go to IDLE. Requesters have no response backpressure.
- Flush: if i_ifu_flush = 1 in any cycle while owner = IFU and state is REQ, WAIT, or RESP, set a drop flag. The bus transaction still completes, but o_ifu_rvalid is suppressed. The flag clears on return to IDLE. Flush has no effect on the LSU.
- rdata/rerr outputs are 0 whenever their rvalid is 0.
- Reset (i_reset = 0, sampled at a clock edge): state goes to IDLE, drop flag goes to 0, last-grant goes to IFU, and all outputs go to 0. An in-flight transaction is abandoned. The bus bridge shares the same reset.

## Timing
- Minimum latency: request accepted at edge t (IDLE), o_mem_valid high in cycle t+1, i_mem_ready in t+1 moves to WAIT at t+2, i_mem_rvalid in t+2 moves to RESP at t+3, rvalid pulse in cycle t+3, IDLE at t+4. That is 4 cycles accept-to-accept.
- o_mem_valid stays high, with fields unchanged, until i_mem_ready is sampled high.
- Only one transaction is outstanding. There is no pipelining.
- Requester fields need only be valid in the acceptance cycle.

## Configuration
- CONFIG_ARB_RR_EN defined: round-robin arbitration. When both valids are asserted in IDLE, the requester not granted last wins. The last-grant register updates on every grant and resets to IFU, so the first conflict goes to the LSU.
- Not defined: fixed priority, where the LSU always wins a conflict. The last-grant register is not built.
- Single-requester behaviour is identical in both modes.

## Test plan
- IFU read at addr 0x8000_0000, bus ready and rvalid immediate with rdata 0x0000_0413 -> o_ifu_ready in cycle 0, o_mem_valid in cycle 1, o_ifu_rvalid with 0x0000_0413 in cycle 3, o_lsu_rvalid never asserted.
- LSU write addr 0xA000_03F8, wdata 0x41, wmask 0001, i_mem_ready delayed 3 cycles -> o_mem_valid held 4 cycles with stable fields, o_lsu_rvalid pulse 2 cycles after the ready handshake when rvalid is immediate.
- Both valids held continuously for 4 transactions -> with CONFIG_ARB_RR_EN, grant order LSU, IFU, LSU, IFU. Without it, LSU four times.
- IFU read in flight, i_ifu_flush pulsed in WAIT, response arrives -> no o_ifu_rvalid. The next IFU request completes normally.
- LSU read returns i_mem_rerr = 1 -> o_lsu_rvalid = 1 and o_lsu_rerr = 1 for one cycle, then IDLE.
- i_reset = 0 asserted during WAIT -> next cycle all outputs are 0 and state is IDLE. A stray i_mem_rvalid after reset produces no response pulse.

Source files
------------

// File: rtl/ysyx_24110006_mem_arbiter_if.sv
// Signal bundle between the memory arbiter, its two requesters (IFU, LSU)
// and the bus bridge. The "slave" modport is the arbiter's view; the
// "master" modport is the view of whatever surrounds it.
interface ysyx_24110006_mem_arbiter_if;
  // IFU side
  logic        i_ifu_valid;
  logic        o_ifu_ready;
  logic [31:0] i_ifu_addr;
  logic        i_ifu_flush;
  logic        o_ifu_rvalid;
  logic [31:0] o_ifu_rdata;
  logic        o_ifu_rerr;
  // LSU side
  logic        i_lsu_valid;
  logic        o_lsu_ready;
  logic [31:0] i_lsu_addr;
  logic        i_lsu_wen;
  logic [31:0] i_lsu_wdata;
  logic [3:0]  i_lsu_wmask;
  logic        o_lsu_rvalid;
  logic [31:0] o_lsu_rdata;
  logic        o_lsu_rerr;
  // Memory bus side
  logic        o_mem_valid;
  logic        i_mem_ready;
  logic [31:0] o_mem_addr;
  logic        o_mem_wen;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_wmask;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;
  logic        i_mem_rerr;

  modport slave (
    input  i_ifu_valid, i_ifu_addr, i_ifu_flush,
    output o_ifu_ready, o_ifu_rvalid, o_ifu_rdata, o_ifu_rerr,
    input  i_lsu_valid, i_lsu_addr, i_lsu_wen, i_lsu_wdata, i_lsu_wmask,
    output o_lsu_ready, o_lsu_rvalid, o_lsu_rdata, o_lsu_rerr,
    output o_mem_valid, o_mem_addr, o_mem_wen, o_mem_wdata, o_mem_wmask,
    input  i_mem_ready, i_mem_rvalid, i_mem_rdata, i_mem_rerr
  );

  modport master (
    output i_ifu_valid, i_ifu_addr, i_ifu_flush,
    input  o_ifu_ready, o_ifu_rvalid, o_ifu_rdata, o_ifu_rerr,
    output i_lsu_valid, i_lsu_addr, i_lsu_wen, i_lsu_wdata, i_lsu_wmask,
    input  o_lsu_ready, o_lsu_rvalid, o_lsu_rdata, o_lsu_rerr,
    input  o_mem_valid, o_mem_addr, o_mem_wen, o_mem_wdata, o_mem_wmask,
    output i_mem_ready, i_mem_rvalid, i_mem_rdata, i_mem_rerr
  );
endinterface

// File: rtl/ysyx_24110006_mem_arbiter.sv
// Two-requester memory arbiter: shares the single bus port between the IFU
// and the LSU, one transaction at a time (IDLE -> REQ -> WAIT -> RESP).
// Optional feature macro: CONFIG_ARB_RR_EN selects round-robin arbitration;
// without it the LSU wins every conflict.
module ysyx_24110006_mem_arbiter (
  input logic                        i_clock,
  input logic                        i_reset,
  ysyx_24110006_mem_arbiter_if.slave arb
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  localparam logic OWNER_IFU = 1'b0;
  localparam logic OWNER_LSU = 1'b1;

  logic [1:0]  state;
  logic [1:0]  state_next;
  logic        owner;
  logic        drop;
  logic [31:0] addr_q;
  logic        wen_q;
  logic [31:0] wdata_q;
  logic [3:0]  wmask_q;
  logic [31:0] rdata_q;
  logic        rerr_q;
  logic        grant_ifu;
  logic        grant_lsu;
  logic        flush_hit;
  logic        ifu_resp;
  logic        lsu_resp;

`ifdef CONFIG_ARB_RR_EN
  logic last_grant;

  // Grant in IDLE only; on a conflict the requester not served last wins
  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    if (state == IDLE && i_reset) begin
      if (arb.i_ifu_valid && arb.i_lsu_valid) begin
        if (last_grant == OWNER_IFU) grant_lsu = 1'b1;
        else                         grant_ifu = 1'b1;
      end else begin
        grant_ifu = arb.i_ifu_valid;
        grant_lsu = arb.i_lsu_valid;
      end
    end
  end

  // Remember who was granted last so the next conflict alternates
  always_ff @(posedge i_clock) begin
    if (!i_reset)       last_grant <= OWNER_IFU;
    else if (grant_lsu) last_grant <= OWNER_LSU;
    else if (grant_ifu) last_grant <= OWNER_IFU;
  end
`else
  // Grant in IDLE only; the LSU always wins a conflict
  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    if (state == IDLE && i_reset) begin
      grant_lsu = arb.i_lsu_valid;
      grant_ifu = arb.i_ifu_valid && !arb.i_lsu_valid;
    end
  end
`endif

  // Next-state logic for the single-outstanding transaction sequence
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_ifu || grant_lsu) state_next = REQ;
      REQ:     if (arb.i_mem_ready)        state_next = WAIT;
      WAIT:    if (arb.i_mem_rvalid)       state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register; reset abandons any in-flight transaction
  always_ff @(posedge i_clock) begin
    if (!i_reset) state <= IDLE;
    else          state <= state_next;
  end

  // Capture the winning request at acceptance and the bus response in WAIT
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      owner   <= OWNER_IFU;
      addr_q  <= 32'd0;
      wen_q   <= 1'b0;
      wdata_q <= 32'd0;
      wmask_q <= 4'd0;
      rdata_q <= 32'd0;
      rerr_q  <= 1'b0;
    end else begin
      if (grant_lsu) begin
        owner   <= OWNER_LSU;
        addr_q  <= arb.i_lsu_addr;
        wen_q   <= arb.i_lsu_wen;
        wdata_q <= arb.i_lsu_wdata;
        wmask_q <= arb.i_lsu_wen ? arb.i_lsu_wmask : 4'd0;
      end else if (grant_ifu) begin
        owner   <= OWNER_IFU;
        addr_q  <= arb.i_ifu_addr;
        wen_q   <= 1'b0;
        wdata_q <= 32'd0;
        wmask_q <= 4'd0;
      end
      if (state == WAIT && arb.i_mem_rvalid) begin
        rdata_q <= arb.i_mem_rdata;
        rerr_q  <= arb.i_mem_rerr;
      end
    end
  end

  assign flush_hit = arb.i_ifu_flush && (owner == OWNER_IFU) && (state != IDLE);

  // Drop flag: a flushed IFU transaction still completes on the bus but
  // its response is swallowed; the flag lives until the next IDLE
  always_ff @(posedge i_clock) begin
    if (!i_reset)           drop <= 1'b0;
    else if (state == IDLE) drop <= 1'b0;
    else if (flush_hit)     drop <= 1'b1;
  end

  // A flush arriving in the RESP cycle itself also suppresses the pulse
  assign ifu_resp = (state == RESP) && (owner == OWNER_IFU) && !drop && !arb.i_ifu_flush;
  assign lsu_resp = (state == RESP) && (owner == OWNER_LSU);

  assign arb.o_ifu_ready  = grant_ifu;
  assign arb.o_lsu_ready  = grant_lsu;
  assign arb.o_ifu_rvalid = ifu_resp;
  assign arb.o_ifu_rdata  = ifu_resp ? rdata_q : 32'd0;
  assign arb.o_ifu_rerr   = ifu_resp && rerr_q;
  assign arb.o_lsu_rvalid = lsu_resp;
  assign arb.o_lsu_rdata  = lsu_resp ? rdata_q : 32'd0;
  assign arb.o_lsu_rerr   = lsu_resp && rerr_q;
  assign arb.o_mem_valid  = (state == REQ);
  assign arb.o_mem_addr   = addr_q;
  assign arb.o_mem_wen    = wen_q;
  assign arb.o_mem_wdata  = wdata_q;
  assign arb.o_mem_wmask  = wmask_q;

endmodule

// File: tb/tb_ysyx_24110006_mem_arbiter.sv
// Self-checking bench for ysyx_24110006_mem_arbiter. Honours the
// CONFIG_ARB_RR_EN macro when predicting conflict winners.
module tb_ysyx_24110006_mem_arbiter;

  logic clock = 1'b0;
  logic reset_n;

  always #5 clock = ~clock;

  ysyx_24110006_mem_arbiter_if arb_if ();

  ysyx_24110006_mem_arbiter dut (
    .i_clock (clock),
    .i_reset (reset_n),
    .arb     (arb_if)
  );

  typedef struct {
    bit          who_lsu;
    logic [31:0] rdata;
    logic        rerr;
  } resp_t;

  int    checks = 0;
  int    errors = 0;
  resp_t sb[$];
  resp_t mon_r;
  bit    model_last_lsu;
  bit    monitor_en;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_readies"}, {arb_if.o_ifu_ready, arb_if.o_lsu_ready}, 0);
    checkOutput({tag, "_ifu_resp"}, {arb_if.o_ifu_rvalid, arb_if.o_ifu_rerr, arb_if.o_ifu_rdata}, 0);
    checkOutput({tag, "_lsu_resp"}, {arb_if.o_lsu_rvalid, arb_if.o_lsu_rerr, arb_if.o_lsu_rdata}, 0);
    checkOutput({tag, "_mem_ctl"}, {arb_if.o_mem_valid, arb_if.o_mem_wen, arb_if.o_mem_wmask}, 0);
    checkOutput({tag, "_mem_data"}, {arb_if.o_mem_addr, arb_if.o_mem_wdata}, 0);
  endtask

  // Monitor: every response pulse must match the oldest expected response
  always @(negedge clock) begin
    #2;
    if (monitor_en) begin
      if (arb_if.o_ifu_rvalid || arb_if.o_lsu_rvalid) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_rvalid", {arb_if.o_ifu_rvalid, arb_if.o_lsu_rvalid}, 0);
        end else begin
          mon_r = sb.pop_front();
          checkOutput("resp_route", {arb_if.o_ifu_rvalid, arb_if.o_lsu_rvalid},
                      {!mon_r.who_lsu, mon_r.who_lsu});
          if (mon_r.who_lsu)
            checkOutput("lsu_resp_data", {arb_if.o_lsu_rerr, arb_if.o_lsu_rdata}, {mon_r.rerr, mon_r.rdata});
          else
            checkOutput("ifu_resp_data", {arb_if.o_ifu_rerr, arb_if.o_ifu_rdata}, {mon_r.rerr, mon_r.rdata});
        end
      end
      if (!arb_if.o_ifu_rvalid)
        checkOutput("ifu_rdata_gated", {arb_if.o_ifu_rerr, arb_if.o_ifu_rdata}, 0);
      if (!arb_if.o_lsu_rvalid)
        checkOutput("lsu_rdata_gated", {arb_if.o_lsu_rerr, arb_if.o_lsu_rdata}, 0);
    end
  end

  // One full transaction, cycle by cycle; flush_at: -1 none, 0 in REQ, 1 in WAIT
  task automatic applyStimulus(input bit ifu_v, input bit lsu_v,
                               input logic [31:0] ifu_addr, input logic [31:0] lsu_addr,
                               input logic lsu_wen, input logic [31:0] lsu_wdata,
                               input logic [3:0] lsu_wmask, input int rdy_dly, input int rv_dly,
                               input int flush_at, input logic [31:0] rdata, input logic rerr,
                               input bit stray);
    bit          win_lsu;
    logic [31:0] e_addr;
    logic        e_wen;
    logic [3:0]  e_wmask;
    bit          dropped;
    resp_t       e;
    if (ifu_v && lsu_v) begin
`ifdef CONFIG_ARB_RR_EN
      win_lsu = !model_last_lsu;
`else
      win_lsu = 1'b1;
`endif
    end else begin
      win_lsu = lsu_v;
    end
    model_last_lsu = win_lsu;
    e_addr  = win_lsu ? lsu_addr : ifu_addr;
    e_wen   = win_lsu && lsu_wen;
    e_wmask = e_wen ? lsu_wmask : 4'd0;
    dropped = (flush_at >= 0) && !win_lsu;

    // Acceptance cycle
    @(negedge clock);
    arb_if.i_ifu_valid = ifu_v;
    arb_if.i_ifu_addr  = ifu_addr;
    arb_if.i_lsu_valid = lsu_v;
    arb_if.i_lsu_addr  = lsu_addr;
    arb_if.i_lsu_wen   = lsu_wen;
    arb_if.i_lsu_wdata = lsu_wdata;
    arb_if.i_lsu_wmask = lsu_wmask;
    #1;
    checkOutput("grant", {arb_if.o_ifu_ready, arb_if.o_lsu_ready}, {!win_lsu, win_lsu});

    // Request phase: fields scrambled at the requester, must stay latched
    @(negedge clock);
    arb_if.i_ifu_valid = 1'b0;
    arb_if.i_lsu_valid = 1'b0;
    arb_if.i_ifu_addr  = $urandom;
    arb_if.i_lsu_addr  = $urandom;
    arb_if.i_lsu_wdata = $urandom;
    arb_if.i_lsu_wmask = 4'($urandom);
    for (int d = 0; d <= rdy_dly; d++) begin
      arb_if.i_mem_ready  = (d == rdy_dly);
      arb_if.i_mem_rvalid = stray && (d == 0);
      arb_if.i_ifu_flush  = (flush_at == 0) && (d == 0);
      #1;
      checkOutput("mem_valid_req", {arb_if.o_mem_valid, arb_if.o_ifu_ready, arb_if.o_lsu_ready}, 3'b100);
      checkOutput("mem_addr", arb_if.o_mem_addr, e_addr);
      checkOutput("mem_wen_wmask", {arb_if.o_mem_wen, arb_if.o_mem_wmask}, {e_wen, e_wmask});
      if (e_wen) checkOutput("mem_wdata", arb_if.o_mem_wdata, lsu_wdata);
      @(negedge clock);
    end
    arb_if.i_mem_ready  = 1'b0;
    arb_if.i_mem_rvalid = 1'b0;
    arb_if.i_ifu_flush  = 1'b0;

    // Wait phase
    for (int d = 0; d <= rv_dly; d++) begin
      arb_if.i_ifu_flush = (flush_at == 1) && (d == 0);
      #1;
      checkOutput("mem_valid_wait", arb_if.o_mem_valid, 0);
      if (d == rv_dly) begin
        arb_if.i_mem_rvalid = 1'b1;
        arb_if.i_mem_rdata  = rdata;
        arb_if.i_mem_rerr   = rerr;
        if (!dropped) begin
          e.who_lsu = win_lsu;
          e.rdata   = rdata;
          e.rerr    = rerr;
          sb.push_back(e);
        end
      end
      @(negedge clock);
      arb_if.i_ifu_flush = 1'b0;
    end
    arb_if.i_mem_rvalid = 1'b0;
    arb_if.i_mem_rdata  = $urandom;
    arb_if.i_mem_rerr   = 1'b0;

    // Response cycle: the monitor consumes the pulse at +2
    #3;
    checkOutput("resp_delivered", sb.size(), 0);
  endtask

  // Hard time limit so the bench can never hang
  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  // Main stimulus sequence
  initial begin
    int pat;
    reset_n             = 1'b0;
    monitor_en          = 1'b0;
    model_last_lsu      = 1'b0;
    arb_if.i_ifu_valid  = 1'b0;
    arb_if.i_ifu_addr   = 32'd0;
    arb_if.i_ifu_flush  = 1'b0;
    arb_if.i_lsu_valid  = 1'b0;
    arb_if.i_lsu_addr   = 32'd0;
    arb_if.i_lsu_wen    = 1'b0;
    arb_if.i_lsu_wdata  = 32'd0;
    arb_if.i_lsu_wmask  = 4'd0;
    arb_if.i_mem_ready  = 1'b0;
    arb_if.i_mem_rvalid = 1'b0;
    arb_if.i_mem_rdata  = 32'd0;
    arb_if.i_mem_rerr   = 1'b0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    checkAllZero("reset");
    monitor_en = 1'b1;

    $display("[TB] IFU read, zero-latency bus");
    applyStimulus(1, 0, 32'h8000_0000, 32'd0, 0, 32'd0, 4'd0, 0, 0, -1, 32'h0000_0413, 0, 0);

    $display("[TB] LSU byte write with delayed bus ready");
    applyStimulus(0, 1, 32'd0, 32'hA000_03F8, 1, 32'h41, 4'b0001, 3, 0, -1, $urandom, 0, 0);

    $display("[TB] four back-to-back conflicts");
    for (int i = 0; i < 4; i++)
      applyStimulus(1, 1, 32'h8000_0000 + 32'(i * 4), 32'h9000_0000 + 32'(i * 4), 0, 32'd0, 4'hF,
                    0, 0, -1, $urandom, 0, 0);

    $display("[TB] IFU flush during WAIT, then normal IFU read");
    applyStimulus(1, 0, 32'h8000_0100, 32'd0, 0, 32'd0, 4'd0, 1, 2, 1, 32'hDEAD_BEEF, 0, 0);
    applyStimulus(1, 0, 32'h8000_0104, 32'd0, 0, 32'd0, 4'd0, 0, 1, -1, 32'h1234_5678, 0, 0);

    $display("[TB] LSU read with bus error");
    applyStimulus(0, 1, 32'd0, 32'hA000_0000, 0, 32'd0, 4'hF, 0, 0, -1, 32'hCAFE_0001, 1, 0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 200; i++) begin
      pat = $urandom_range(1, 3);
      applyStimulus(pat[0], pat[1], $urandom, $urandom, 1'($urandom), $urandom, 4'($urandom),
                    $urandom_range(0, 3), $urandom_range(0, 3),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1)) : -1,
                    $urandom, ($urandom_range(0, 7) == 0), 1'($urandom));
    end

    $display("[TB] reset asserted during WAIT");
    @(negedge clock);
    arb_if.i_lsu_valid = 1'b1;
    arb_if.i_lsu_addr  = 32'hA000_0010;
    arb_if.i_lsu_wen   = 1'b0;
    #1;
    checkOutput("rst_grant", {arb_if.o_ifu_ready, arb_if.o_lsu_ready}, 2'b01);
    @(negedge clock);
    arb_if.i_lsu_valid = 1'b0;
    arb_if.i_mem_ready = 1'b1;
    @(negedge clock);
    arb_if.i_mem_ready = 1'b0;
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    model_last_lsu = 1'b0;
    #1;
    checkAllZero("post_reset");
    arb_if.i_mem_rvalid = 1'b1;
    arb_if.i_mem_rdata  = 32'h5555_AAAA;
    @(negedge clock);
    arb_if.i_mem_rvalid = 1'b0;
    repeat (3) begin
      @(negedge clock);
      #1;
      checkAllZero("stray_rvalid");
    end

    $display("[TB] conflict right after reset");
    applyStimulus(1, 1, 32'h8000_0200, 32'hA000_0200, 0, 32'd0, 4'd0, 0, 0, -1, $urandom, 0, 0);

    repeat (3) @(negedge clock);
    checkOutput("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
